// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-flop synchronizer, oversampled start/data/parity/stop
// recovery, one-entry valid/ready output with status. Define RX_MAJORITY_VOTE_EN for 2-of-3 bit voting.
module uart_rx_deserializer #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 sample_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 clear_overrun,
   output logic                 busy
);

   localparam int unsigned TCW  = $clog2(OVERSAMPLE);
   localparam int unsigned BCW  = $clog2(DATA_BITS + 1);
   localparam int unsigned HALF = OVERSAMPLE / 2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [TCW-1:0]       tick_q, tick_d;
   logic [BCW-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_meta, rx_s, rx_mid;
   logic                 bit_c, end_c, deliver_c, load_c;

   // Decisions are taken one tick after the bit centre so both builds share timing.
`ifdef RX_MAJORITY_VOTE_EN
   logic rx_early;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rx_early <= 1'b1;
      else if (sample_tick) rx_early <= rx_mid;
   end

   assign bit_c = (rx_early & rx_mid) | (rx_early & rx_s) | (rx_mid & rx_s);
`else
   assign bit_c = rx_mid;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_mid  <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         if (sample_tick) rx_mid <= rx_s;
      end
   end

   assign end_c = sample_tick &&
                  (tick_q == ((state_q == S_START) ? TCW'(HALF) : TCW'(OVERSAMPLE - 1)));

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      deliver_c = 1'b0;
      if (state_q != S_IDLE && sample_tick)
         tick_d = end_c ? '0 : tick_q + TCW'(1);
      case (state_q)
         S_IDLE: begin
            if (sample_tick && !rx_s) begin
               state_d = S_START;
               tick_d  = '0;
               bit_d   = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         S_START: begin
            if (end_c) state_d = bit_c ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (end_c) begin
               shreg_d = {bit_c, shreg_q[DATA_BITS-1:1]};
               if (bit_q == BCW'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BCW'(1);
               end
            end
         end
         S_PARITY: begin
            if (end_c) begin
               perr_d  = (PARITY == 1) ? ~(^shreg_q ^ bit_c) : (^shreg_q ^ bit_c);
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (end_c) begin
               if (!bit_c) ferr_d = 1'b1;
               if (bit_q == BCW'(STOP_BITS - 1)) begin
                  state_d   = S_IDLE;
                  deliver_c = 1'b1;
               end else begin
                  bit_d = bit_q + BCW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   // Output holding register; a frame arriving while the held word is not consumed is dropped.
   assign load_c = deliver_c && (!valid || ready);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         busy <= (state_d != S_IDLE);
         if (load_c) begin
            data       <= shreg_q;
            parity_err <= perr_q;
            frame_err  <= ferr_d;
            valid      <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         if (deliver_c && !load_c) overrun <= 1'b1;
         else if (clear_overrun)   overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_deserializer;

   logic       clock, reset_n, sample_tick, ready, clear_overrun;
   logic       rx_a, rx_p;
   logic [7:0] data_a, data_p;
   logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
   logic       valid_p, perr_p, ferr_p, ovr_p, busy_p;

   int         vectors = 0;
   int         errors  = 0;
   int         div_cnt = 0;
   logic [9:0] exp_a[$];
   logic [9:0] exp_p[$];

`ifdef RX_MAJORITY_VOTE_EN
   localparam bit SPIKE = 1'b1;
`else
   localparam bit SPIKE = 1'b0;
`endif

   uart_rx_deserializer dut_a (
      .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick), .rx(rx_a),
      .data(data_a), .valid(valid_a), .ready(ready), .parity_err(perr_a),
      .frame_err(ferr_a), .overrun(ovr_a), .clear_overrun(clear_overrun), .busy(busy_a)
   );

   uart_rx_deserializer #(.PARITY(2)) dut_p (
      .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick), .rx(rx_p),
      .data(data_p), .valid(valid_p), .ready(ready), .parity_err(perr_p),
      .frame_err(ferr_p), .overrun(ovr_p), .clear_overrun(clear_overrun), .busy(busy_p)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One sample tick every fourth clock, changed away from the active edge.
   initial begin
      sample_tick = 1'b0;
      forever begin
         @(negedge clock);
         sample_tick = (div_cnt == 0);
         div_cnt = (div_cnt + 1) % 4;
      end
   end

   always @(negedge clock) begin
      logic [9:0] e;
      if (reset_n && valid_a && ready) begin
         vectors++;
         if (exp_a.size() == 0) begin
            errors++;
            $display("FAIL sb_a unexpected word data=%h perr=%b ferr=%b", data_a, perr_a, ferr_a);
         end else begin
            e = exp_a.pop_front();
            if ({data_a, perr_a, ferr_a} !== e) begin
               errors++;
               $display("FAIL sb_a got data=%h perr=%b ferr=%b expected data=%h perr=%b ferr=%b",
                        data_a, perr_a, ferr_a, e[9:2], e[1], e[0]);
            end
         end
      end
      if (reset_n && valid_p && ready) begin
         vectors++;
         if (exp_p.size() == 0) begin
            errors++;
            $display("FAIL sb_p unexpected word data=%h perr=%b ferr=%b", data_p, perr_p, ferr_p);
         end else begin
            e = exp_p.pop_front();
            if ({data_p, perr_p, ferr_p} !== e) begin
               errors++;
               $display("FAIL sb_p got data=%h perr=%b ferr=%b expected data=%h perr=%b ferr=%b",
                        data_p, perr_p, ferr_p, e[9:2], e[1], e[0]);
            end
         end
      end
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         while (!sample_tick) @(posedge clock);
      end
      #1;
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) rx_p = v;
      else     rx_a = v;
   endtask

   // Bit windows of 16 ticks; the spike inverts the line for the tick at the centre of bit 0.
   task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                             input bit pbit, input bit stop_val, input bit spike);
      drive(sel, 1'b0);
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         drive(sel, d[i]);
         if (spike && i == 0) begin
            wait_ticks(8);
            drive(sel, ~d[i]);
            wait_ticks(1);
            drive(sel, d[i]);
            wait_ticks(7);
         end else begin
            wait_ticks(16);
         end
      end
      if (has_par) begin
         drive(sel, pbit);
         wait_ticks(16);
      end
      drive(sel, stop_val);
      wait_ticks(16);
      drive(sel, 1'b1);
      wait_ticks(24);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; rx_a = 1'b1; rx_p = 1'b1; ready = 1'b1; clear_overrun = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      vectors++;
      if ({data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a} !== 13'h0) begin
         errors++;
         $display("FAIL reset_a got %h expected 0", {data_a, valid_a, perr_a, ferr_a, ovr_a, busy_a});
      end
      vectors++;
      if ({data_p, valid_p, perr_p, ferr_p, ovr_p, busy_p} !== 13'h0) begin
         errors++;
         $display("FAIL reset_p got %h expected 0", {data_p, valid_p, perr_p, ferr_p, ovr_p, busy_p});
      end
      reset_n = 1'b1;
      wait_ticks(4);
   endtask

   task automatic test_basic;
      exp_a.push_back({8'hA5, 1'b0, 1'b0});
      fork
         send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
         begin
            wait_ticks(80);
            vectors++;
            if (busy_a !== 1'b1) begin
               errors++;
               $display("FAIL basic_busy_mid got %b expected 1", busy_a);
            end
         end
      join
      vectors++;
      if ({busy_a, valid_a} !== 2'b00) begin
         errors++;
         $display("FAIL basic_idle got busy=%b valid=%b expected 0 0", busy_a, valid_a);
      end
      vectors++;
      if (exp_a.size() != 0) begin
         errors++;
         $display("FAIL basic_drain got %0d pending expected 0", exp_a.size());
      end
   endtask

   task automatic test_glitch;
      rx_a = 1'b0;
      wait_ticks(2);
      vectors++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy got %b expected 1", busy_a);
      end
      wait_ticks(2);
      rx_a = 1'b1;
      wait_ticks(24);
      vectors++;
      if ({busy_a, valid_a, ovr_a} !== 3'b000) begin
         errors++;
         $display("FAIL glitch_idle got busy=%b valid=%b ovr=%b expected 0 0 0", busy_a, valid_a, ovr_a);
      end
   endtask

   task automatic test_parity;
      for (int p = 0; p < 2; p++) begin
         exp_p.push_back({8'h07, ((^8'h07) ^ p[0]), 1'b0});
         send_frame(1'b1, 8'h07, 1'b1, p[0], 1'b1, 1'b0);
      end
      vectors++;
      if (exp_p.size() != 0) begin
         errors++;
         $display("FAIL parity_drain got %0d pending expected 0", exp_p.size());
      end
   endtask

   task automatic test_frame_err;
      exp_a.push_back({8'h3C, 1'b0, 1'b1});
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_a.push_back({8'h11, 1'b0, 1'b0});
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (exp_a.size() != 0) begin
         errors++;
         $display("FAIL frame_drain got %0d pending expected 0", exp_a.size());
      end
   endtask

   task automatic test_overrun;
      ready = 1'b0;
      exp_a.push_back({8'h55, 1'b0, 1'b0});
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if ({valid_a, data_a, ovr_a} !== {1'b1, 8'h55, 1'b1}) begin
         errors++;
         $display("FAIL overrun_hold got valid=%b data=%h ovr=%b expected 1 55 1", valid_a, data_a, ovr_a);
      end
      ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      vectors++;
      if ({valid_a, ovr_a} !== 2'b01) begin
         errors++;
         $display("FAIL overrun_drain got valid=%b ovr=%b expected 0 1", valid_a, ovr_a);
      end
      clear_overrun = 1'b1;
      @(posedge clock);
      #1;
      clear_overrun = 1'b0;
      vectors++;
      if (ovr_a !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear got %b expected 0", ovr_a);
      end
      vectors++;
      if (exp_a.size() != 0) begin
         errors++;
         $display("FAIL overrun_queue got %0d pending expected 0", exp_a.size());
      end
   endtask

   task automatic test_reset_abort;
      rx_a = 1'b0;
      wait_ticks(16 + 32 + 8);
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({busy_a, valid_a} !== 2'b00) begin
         errors++;
         $display("FAIL abort_reset got busy=%b valid=%b expected 0 0", busy_a, valid_a);
      end
      repeat (3) @(posedge clock);
      #1;
      rx_a = 1'b1;
      reset_n = 1'b1;
      wait_ticks(40);
      vectors++;
      if ({busy_a, valid_a} !== 2'b00) begin
         errors++;
         $display("FAIL abort_idle got busy=%b valid=%b expected 0 0", busy_a, valid_a);
      end
      exp_a.push_back({8'h81, 1'b0, 1'b0});
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, SPIKE);
      vectors++;
      if (exp_a.size() != 0) begin
         errors++;
         $display("FAIL abort_drain got %0d pending expected 0", exp_a.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_parity();
      test_frame_err();
      test_overrun();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
